// File: rtl/hi_term_decoder.sv
// hi_term_decoder
// Routes one Host Interface device bus to NUM_DEVS device buses selected by
// terminal address. The target is decoded once per transaction and held
// until host mode drops. Unmapped terminals and devices that stall past the
// watchdog limit are answered locally so the host always completes.
//
// Handshake: a transaction lasts while mode (di_read_mode | di_write_mode)
// is high. Once a device is selected, its rdy/data/status reach the host
// combinationally in the same cycle; the host treats rdy high as completion
// of the beat it is presenting. Device controls are gated by the host's own
// mode, so they fall in the same cycle the host drops mode.
module hi_term_decoder #(
    parameter int                     NUM_DEVS       = 2,
    parameter logic [16*NUM_DEVS-1:0] TERM_BASE      = {NUM_DEVS{16'h0}},
    parameter logic [16*NUM_DEVS-1:0] TERM_MASK      = {NUM_DEVS{16'hFFFF}},
    parameter int                     TIMEOUT_CYCLES = 1024
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    // host side
    input  logic [15:0]              di_term_addr,
    input  logic [31:0]              di_reg_addr,
    input  logic [31:0]              di_len,
    input  logic                     di_read_mode,
    input  logic                     di_read_req,
    input  logic                     di_read,
    output logic                     di_read_rdy,
    output logic [31:0]              di_reg_datao,
    input  logic                     di_write_mode,
    input  logic                     di_write,
    input  logic [31:0]              di_reg_datai,
    output logic                     di_write_rdy,
    output logic [15:0]              di_transfer_status,
    // device side, slice k belongs to device k
    output logic [16*NUM_DEVS-1:0]   O_di_term_addr,
    output logic [32*NUM_DEVS-1:0]   O_di_reg_addr,
    output logic [32*NUM_DEVS-1:0]   O_di_len,
    output logic [32*NUM_DEVS-1:0]   O_di_reg_datai,
    output logic [NUM_DEVS-1:0]      O_di_read_mode,
    output logic [NUM_DEVS-1:0]      O_di_read_req,
    output logic [NUM_DEVS-1:0]      O_di_read,
    output logic [NUM_DEVS-1:0]      O_di_write_mode,
    output logic [NUM_DEVS-1:0]      O_di_write,
    input  logic [NUM_DEVS-1:0]      I_di_read_rdy,
    input  logic [NUM_DEVS-1:0]      I_di_write_rdy,
    input  logic [32*NUM_DEVS-1:0]   I_di_reg_datao,
    input  logic [16*NUM_DEVS-1:0]   I_di_transfer_status,
    // error pulses and state visibility
    output logic                     unmapped_evt,
    output logic                     timeout_evt,
    output logic [1:0]               dbg_state_o
);

    localparam int SEL_W  = (NUM_DEVS > 1) ? $clog2(NUM_DEVS) : 1;
    localparam bit WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LIM = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
    // Count value that, seen together with another not-ready cycle, makes
    // the TIMEOUT_CYCLES-th consecutive stall.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [31:0] FILL_DATA   = 32'hDEAD_BEEF;
    localparam logic [15:0] ST_UNMAPPED = 16'hE001;
    localparam logic [15:0] ST_TIMEOUT  = 16'hE002;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY     = 2'd1,
        S_UNMAPPED = 2'd2,
        S_TIMEOUT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               pend_req_q, pend_req_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic               unmapped_evt_q, unmapped_evt_d;
    logic               timeout_evt_q, timeout_evt_d;

    logic               mode;
    logic               dec_hit;
    logic [SEL_W-1:0]   dec_idx;
    logic               sel_rd_rdy;
    logic               sel_wr_rdy;
    logic [31:0]        sel_rdata;
    logic [15:0]        sel_status;
    logic               wd_rdy;

    assign mode = di_read_mode | di_write_mode;

    // Address, length and write data go to every device unconditionally.
    assign O_di_term_addr = {NUM_DEVS{di_term_addr}};
    assign O_di_reg_addr  = {NUM_DEVS{di_reg_addr}};
    assign O_di_len       = {NUM_DEVS{di_len}};
    assign O_di_reg_datai = {NUM_DEVS{di_reg_datai}};

    assign unmapped_evt = unmapped_evt_q;
    assign timeout_evt  = timeout_evt_q;
    assign dbg_state_o  = state_q;

    // Terminal decode: scanning downward leaves the lowest matching device.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NUM_DEVS - 1; k >= 0; k--) begin
            if ((di_term_addr & TERM_MASK[16*k +: 16]) == TERM_BASE[16*k +: 16]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(k);
            end
        end
    end

    // Pick the latched device's response signals.
    always_comb begin
        sel_rd_rdy = 1'b0;
        sel_wr_rdy = 1'b0;
        sel_rdata  = '0;
        sel_status = '0;
        for (int k = 0; k < NUM_DEVS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_rd_rdy = I_di_read_rdy[k];
                sel_wr_rdy = I_di_write_rdy[k];
                sel_rdata  = I_di_reg_datao[32*k +: 32];
                sel_status = I_di_transfer_status[16*k +: 16];
            end
        end
    end

    // The watchdog follows the handshake of the direction being used.
    assign wd_rdy = di_read_mode ? sel_rd_rdy : sel_wr_rdy;

    // Next-state logic: decode in IDLE, watchdog in BUSY, exit on mode low.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        pend_req_d     = pend_req_q;
        wd_cnt_d       = wd_cnt_q;
        unmapped_evt_d = 1'b0;
        timeout_evt_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                wd_cnt_d   = '0;
                pend_req_d = 1'b0;
                if (mode) begin
                    if (dec_hit) begin
                        state_d    = S_BUSY;
                        sel_d      = dec_idx;
                        pend_req_d = di_read_req;
                    end else begin
                        state_d        = S_UNMAPPED;
                        unmapped_evt_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // The replayed request only lives for the first BUSY cycle.
                pend_req_d = 1'b0;
                if (!mode) begin
                    state_d = S_IDLE;
                end else if (wd_rdy) begin
                    wd_cnt_d = '0;
                end else begin
                    if (wd_cnt_q != CNT_MAX) begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                    if (WD_EN && (wd_cnt_q == TO_LAST)) begin
                        state_d       = S_TIMEOUT;
                        timeout_evt_d = 1'b1;
                    end
                end
            end
            S_UNMAPPED, S_TIMEOUT: begin
                if (!mode) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset returns to IDLE at once, dropping device modes.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= S_IDLE;
            sel_q          <= '0;
            pend_req_q     <= 1'b0;
            wd_cnt_q       <= '0;
            unmapped_evt_q <= 1'b0;
            timeout_evt_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            pend_req_q     <= pend_req_d;
            wd_cnt_q       <= wd_cnt_d;
            unmapped_evt_q <= unmapped_evt_d;
            timeout_evt_q  <= timeout_evt_d;
        end
    end

    // Device controls: only the latched device sees host controls, only in BUSY.
    always_comb begin
        O_di_read_mode  = '0;
        O_di_read_req   = '0;
        O_di_read       = '0;
        O_di_write_mode = '0;
        O_di_write      = '0;
        if (state_q == S_BUSY) begin
            for (int k = 0; k < NUM_DEVS; k++) begin
                if (sel_q == SEL_W'(k)) begin
                    O_di_read_mode[k]  = di_read_mode;
                    O_di_read_req[k]   = di_read_req | pend_req_q;
                    O_di_read[k]       = di_read;
                    O_di_write_mode[k] = di_write_mode;
                    O_di_write[k]      = di_write;
                end
            end
        end
    end

    // Host responses: device pass-through in BUSY, local answers on errors.
    always_comb begin
        di_read_rdy        = 1'b0;
        di_write_rdy       = 1'b0;
        di_reg_datao       = '0;
        di_transfer_status = '0;
        case (state_q)
            S_BUSY: begin
                di_read_rdy        = sel_rd_rdy;
                di_write_rdy       = sel_wr_rdy;
                di_reg_datao       = sel_rdata;
                di_transfer_status = sel_status;
            end
            S_UNMAPPED: begin
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_reg_datao       = FILL_DATA;
                di_transfer_status = ST_UNMAPPED;
            end
            S_TIMEOUT: begin
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_reg_datao       = FILL_DATA;
                di_transfer_status = ST_TIMEOUT;
            end
            default: begin
                di_read_rdy        = 1'b0;
                di_write_rdy       = 1'b0;
                di_reg_datao       = '0;
                di_transfer_status = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hi_term_decoder.sv
// Bench for hi_term_decoder: behavioural devices with programmable stall,
// a transaction driver that records what the host and devices saw, and
// per-scenario tasks comparing those records with expectations derived from
// the terminal map and watchdog rules.
module tb_hi_term_decoder;

    localparam int                N    = 2;
    localparam logic [16*N-1:0]   BASE = {16'h0010, 16'h0000};
    localparam logic [16*N-1:0]   MASK = {16'hFFF0, 16'hFFF0};
    localparam int                TO   = 8;

    // clock / reset
    logic ifclk;
    logic resetb;
    initial ifclk = 1'b0;
    always #5 ifclk = ~ifclk;

    // host side
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr, di_len, di_reg_datai;
    logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic        di_read_rdy, di_write_rdy;
    logic [31:0] di_reg_datao;
    logic [15:0] di_transfer_status;

    // device side of the watchdog-enabled instance
    logic [16*N-1:0] O_di_term_addr;
    logic [32*N-1:0] O_di_reg_addr, O_di_len, O_di_reg_datai;
    logic [N-1:0]    O_di_read_mode, O_di_read_req, O_di_read, O_di_write_mode, O_di_write;
    logic [N-1:0]    I_di_read_rdy, I_di_write_rdy;
    logic [32*N-1:0] I_di_reg_datao;
    logic [16*N-1:0] I_di_transfer_status;
    logic            unmapped_evt, timeout_evt;
    logic [1:0]      dbg_state;

    // watchdog-disabled instance; its devices never become ready
    logic            b_read_rdy, b_write_rdy;
    logic [31:0]     b_reg_datao;
    logic [15:0]     b_status;
    logic [16*N-1:0] b_term_addr;
    logic [32*N-1:0] b_reg_addr, b_len, b_reg_datai;
    logic [N-1:0]    b_read_mode, b_read_req, b_read, b_write_mode, b_write;
    logic [N-1:0]    b_zero_n;
    logic [32*N-1:0] b_zero_d;
    logic [16*N-1:0] b_zero_s;
    logic            b_unmapped_evt, b_timeout_evt;
    logic [1:0]      b_dbg_state;
    assign b_zero_n = '0;
    assign b_zero_d = '0;
    assign b_zero_s = '0;

    hi_term_decoder #(.NUM_DEVS(N), .TERM_BASE(BASE), .TERM_MASK(MASK), .TIMEOUT_CYCLES(TO)) dut (
        .ifclk(ifclk), .resetb(resetb),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
        .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status),
        .O_di_term_addr(O_di_term_addr), .O_di_reg_addr(O_di_reg_addr), .O_di_len(O_di_len),
        .O_di_reg_datai(O_di_reg_datai), .O_di_read_mode(O_di_read_mode),
        .O_di_read_req(O_di_read_req), .O_di_read(O_di_read),
        .O_di_write_mode(O_di_write_mode), .O_di_write(O_di_write),
        .I_di_read_rdy(I_di_read_rdy), .I_di_write_rdy(I_di_write_rdy),
        .I_di_reg_datao(I_di_reg_datao), .I_di_transfer_status(I_di_transfer_status),
        .unmapped_evt(unmapped_evt), .timeout_evt(timeout_evt), .dbg_state_o(dbg_state)
    );

    hi_term_decoder #(.NUM_DEVS(N), .TERM_BASE(BASE), .TERM_MASK(MASK), .TIMEOUT_CYCLES(0)) dut_nowd (
        .ifclk(ifclk), .resetb(resetb),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_read_rdy(b_read_rdy), .di_reg_datao(b_reg_datao),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
        .di_write_rdy(b_write_rdy), .di_transfer_status(b_status),
        .O_di_term_addr(b_term_addr), .O_di_reg_addr(b_reg_addr), .O_di_len(b_len),
        .O_di_reg_datai(b_reg_datai), .O_di_read_mode(b_read_mode),
        .O_di_read_req(b_read_req), .O_di_read(b_read),
        .O_di_write_mode(b_write_mode), .O_di_write(b_write),
        .I_di_read_rdy(b_zero_n), .I_di_write_rdy(b_zero_n),
        .I_di_reg_datao(b_zero_d), .I_di_transfer_status(b_zero_s),
        .unmapped_evt(b_unmapped_evt), .timeout_evt(b_timeout_evt), .dbg_state_o(b_dbg_state)
    );

    // behavioural devices: ready once their mode has been up for stall[k] cycles
    int          stall [N];
    bit          stall_inf [N];
    logic [31:0] dev_rdata [N];
    logic [15:0] dev_status [N];
    int          dev_cnt [N];

    always @(posedge ifclk or negedge resetb) begin
        for (int k = 0; k < N; k++) begin
            if (!resetb) dev_cnt[k] <= 0;
            else if (O_di_read_mode[k] || O_di_write_mode[k]) dev_cnt[k] <= dev_cnt[k] + 1;
            else dev_cnt[k] <= 0;
        end
    end

    always_comb begin
        I_di_read_rdy        = '0;
        I_di_write_rdy       = '0;
        I_di_reg_datao       = '0;
        I_di_transfer_status = '0;
        for (int k = 0; k < N; k++) begin
            I_di_read_rdy[k]  = O_di_read_mode[k] && !stall_inf[k] && (dev_cnt[k] >= stall[k]);
            I_di_write_rdy[k] = O_di_write_mode[k] && !stall_inf[k] && (dev_cnt[k] >= stall[k]);
            I_di_reg_datao[32*k +: 32]       = dev_rdata[k];
            I_di_transfer_status[16*k +: 16] = dev_status[k];
        end
    end

    // scoreboard counters
    int checks;
    int failures;

    // reference terminal map: lowest device whose masked address equals its base
    function automatic int ref_decode(input logic [15:0] t);
        for (int k = 0; k < N; k++) begin
            if ((t & MASK[16*k +: 16]) == BASE[16*k +: 16]) return k;
        end
        return -1;
    endfunction

    // per-transaction record
    int          r_lat, r_viol, r_unm, r_to, r_req, r_req_at;
    logic [31:0] r_data;
    logic [15:0] r_status;

    // Drive one transaction, hold it until the host sees rdy (bounded), then
    // drop mode for one cycle. Device-side activity is compared each cycle
    // against where the terminal map says it should go.
    task automatic run_txn(input bit rd, input logic [15:0] term, input logic [31:0] wdata, input bit req);
        int          d;
        int          to_at;
        bit          done;
        bit          exp_on;
        bit          h_rdy;
        logic [N-1:0] exp_m;
        logic [31:0] radr, rlen;
        d     = ref_decode(term);
        to_at = (d >= 0 && (stall_inf[d] || stall[d] >= TO)) ? TO + 1 : 0;
        radr  = $urandom;
        rlen  = $urandom;
        r_lat = 0; r_viol = 0; r_unm = 0; r_to = 0; r_req = 0; r_req_at = -1;
        r_data = '0; r_status = '0;
        done  = 1'b0;
        @(posedge ifclk); #1;
        di_term_addr = term; di_reg_addr = radr; di_len = rlen; di_reg_datai = wdata;
        di_read_mode = rd; di_read = rd; di_write_mode = !rd; di_write = !rd;
        di_read_req = rd & req;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge ifclk);
            exp_on = (i >= 1) && (d >= 0) && !(to_at != 0 && i >= to_at);
            exp_m  = '0;
            if (exp_on) exp_m[d] = 1'b1;
            if (O_di_read_mode  !== (rd ? exp_m : '0)) r_viol++;
            if (O_di_read       !== (rd ? exp_m : '0)) r_viol++;
            if (O_di_write_mode !== (rd ? '0 : exp_m)) r_viol++;
            if (O_di_write      !== (rd ? '0 : exp_m)) r_viol++;
            if ((O_di_read_req & ~exp_m) !== '0) r_viol++;
            for (int k = 0; k < N; k++) begin
                if (O_di_term_addr[16*k +: 16] !== term || O_di_reg_addr[32*k +: 32] !== radr ||
                    O_di_len[32*k +: 32] !== rlen || O_di_reg_datai[32*k +: 32] !== wdata) r_viol++;
            end
            if (d >= 0 && O_di_read_req[d] === 1'b1) begin r_req++; r_req_at = i; end
            if (unmapped_evt === 1'b1) r_unm++;
            if (timeout_evt === 1'b1) r_to++;
            h_rdy = rd ? di_read_rdy : di_write_rdy;
            if (i == 0 && (di_read_rdy !== 1'b0 || di_write_rdy !== 1'b0)) r_viol++;
            if (i > 0 && h_rdy === 1'b1) begin
                r_lat = i; r_data = di_reg_datao; r_status = di_transfer_status; done = 1'b1;
            end
            @(posedge ifclk); #1;
            di_read_req = 1'b0;
        end
        di_read_mode = 1'b0; di_read = 1'b0; di_write_mode = 1'b0; di_write = 1'b0;
        @(negedge ifclk);
        if ((O_di_read_mode | O_di_write_mode | O_di_read | O_di_write | O_di_read_req) !== '0) r_viol++;
        if (unmapped_evt === 1'b1) r_unm++;
        if (timeout_evt === 1'b1) r_to++;
    endtask

    task automatic test_reset();
        resetb = 1'b1;
        di_term_addr = 16'h0013; di_reg_addr = 32'h0000_0044; di_len = 32'd4;
        di_reg_datai = 32'h5555_AAAA; di_write_mode = 1'b1; di_write = 1'b1;
        di_read_mode = 1'b0; di_read = 1'b0; di_read_req = 1'b0;
        #1 resetb = 1'b0;
        repeat (2) @(posedge ifclk);
        @(negedge ifclk);
        checks++;
        if ((O_di_read_mode | O_di_write_mode | O_di_read | O_di_write | O_di_read_req) !== '0) begin
            failures++; $display("FAIL reset_dev_ctrl got wm=%b rm=%b want all 0", O_di_write_mode, O_di_read_mode);
        end
        checks++;
        if ({di_read_rdy, di_write_rdy} !== 2'b00) begin
            failures++; $display("FAIL reset_host_rdy got %b want 00", {di_read_rdy, di_write_rdy});
        end
        checks++;
        if (di_reg_datao !== 32'h0 || di_transfer_status !== 16'h0) begin
            failures++; $display("FAIL reset_host_data got %h/%h want 0/0", di_reg_datao, di_transfer_status);
        end
        checks++;
        if ({unmapped_evt, timeout_evt} !== 2'b00) begin
            failures++; $display("FAIL reset_evt got %b want 00", {unmapped_evt, timeout_evt});
        end
        checks++;
        if (O_di_term_addr !== {16'h0013, 16'h0013} || O_di_reg_datai !== {32'h5555_AAAA, 32'h5555_AAAA}) begin
            failures++; $display("FAIL reset_broadcast got %h/%h want term 0013 data 5555aaaa", O_di_term_addr, O_di_reg_datai);
        end
        di_write_mode = 1'b0; di_write = 1'b0;
        @(negedge ifclk);
        resetb = 1'b1;
    endtask

    task automatic test_map_decode();
        dev_status[0] = 16'h0F0F; dev_status[1] = 16'hA5A1;
        stall[0] = 0; stall[1] = 2;
        run_txn(1'b0, 16'h0013, 32'h1234_5678, 1'b0);
        checks++;
        if (r_viol !== 0) begin failures++; $display("FAIL map_dev_ctrl got %0d bad cycles want 0", r_viol); end
        checks++;
        if (r_lat !== 3) begin failures++; $display("FAIL map_latency got %0d want 3", r_lat); end
        checks++;
        if (r_status !== 16'hA5A1) begin failures++; $display("FAIL map_status got %h want a5a1", r_status); end
        checks++;
        if (r_unm !== 0 || r_to !== 0) begin failures++; $display("FAIL map_evt got %0d/%0d want 0/0", r_unm, r_to); end
    endtask

    task automatic test_replay_req();
        dev_rdata[0] = 32'hCAFE_0001; stall[0] = 1;
        run_txn(1'b1, 16'h0002, 32'h0, 1'b1);
        checks++;
        if (r_req !== 1 || r_req_at !== 1) begin
            failures++; $display("FAIL replay_req got %0d pulses at %0d want 1 at 1", r_req, r_req_at);
        end
        checks++;
        if (r_data !== 32'hCAFE_0001) begin failures++; $display("FAIL replay_data got %h want cafe0001", r_data); end
        checks++;
        if (r_lat !== 2 || r_viol !== 0) begin
            failures++; $display("FAIL replay_timing got lat %0d viol %0d want 2/0", r_lat, r_viol);
        end
    endtask

    task automatic test_unmapped();
        run_txn(1'b1, 16'h0100, 32'h0, 1'b0);
        checks++;
        if (r_unm !== 1) begin failures++; $display("FAIL unm_evt got %0d cycles want 1", r_unm); end
        checks++;
        if (r_lat !== 1 || r_data !== 32'hDEAD_BEEF || r_status !== 16'hE001) begin
            failures++; $display("FAIL unm_resp got lat %0d data %h st %h want 1 deadbeef e001", r_lat, r_data, r_status);
        end
        checks++;
        if (r_viol !== 0) begin failures++; $display("FAIL unm_dev_ctrl got %0d bad cycles want 0", r_viol); end
    endtask

    task automatic test_watchdog();
        int b_rdy_cnt;
        int b_mode_cnt;
        stall_inf[0] = 1'b1;
        run_txn(1'b1, 16'h0002, 32'h0, 1'b0);
        checks++;
        if (r_lat !== TO + 1) begin failures++; $display("FAIL wd_latency got %0d want %0d", r_lat, TO + 1); end
        checks++;
        if (r_status !== 16'hE002 || r_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wd_resp got %h/%h want e002/deadbeef", r_status, r_data);
        end
        checks++;
        if (r_to !== 1 || r_unm !== 0) begin failures++; $display("FAIL wd_evt got to %0d unm %0d want 1/0", r_to, r_unm); end
        checks++;
        if (r_viol !== 0) begin failures++; $display("FAIL wd_dev_ctrl got %0d bad cycles want 0", r_viol); end
        // with the watchdog disabled the host is left waiting
        b_rdy_cnt = 0; b_mode_cnt = 0;
        @(posedge ifclk); #1;
        di_term_addr = 16'h0002; di_read_mode = 1'b1; di_read = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge ifclk);
            if (b_read_rdy === 1'b1) b_rdy_cnt++;
            if (b_read_mode[0] === 1'b1) b_mode_cnt++;
        end
        checks++;
        if (b_rdy_cnt !== 0 || b_mode_cnt !== 29) begin
            failures++; $display("FAIL nowd_stall got rdy %0d mode %0d want 0/29", b_rdy_cnt, b_mode_cnt);
        end
        @(posedge ifclk); #1;
        di_read_mode = 1'b0; di_read = 1'b0;
        stall_inf[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        dev_rdata[0] = 32'h0000_0A0A; dev_status[1] = 16'h1B1B;
        stall[0] = 0; stall[1] = 1;
        run_txn(1'b1, 16'h0005, 32'h0, 1'b0);
        checks++;
        if (r_viol !== 0 || r_lat !== 1 || r_data !== 32'h0000_0A0A) begin
            failures++; $display("FAIL b2b_first got viol %0d lat %0d data %h want 0/1/00000a0a", r_viol, r_lat, r_data);
        end
        run_txn(1'b0, 16'h001A, 32'h7777_0000, 1'b0);
        checks++;
        if (r_viol !== 0 || r_lat !== 2 || r_status !== 16'h1B1B) begin
            failures++; $display("FAIL b2b_second got viol %0d lat %0d st %h want 0/2/1b1b", r_viol, r_lat, r_status);
        end
    endtask

    task automatic test_reset_mid_busy();
        stall_inf[1] = 1'b1;
        @(posedge ifclk); #1;
        di_term_addr = 16'h0013; di_reg_datai = 32'hABCD_0000; di_write_mode = 1'b1; di_write = 1'b1;
        repeat (3) @(negedge ifclk);
        checks++;
        if (O_di_write_mode !== 2'b10) begin failures++; $display("FAIL rst_busy_pre got %b want 10", O_di_write_mode); end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ((O_di_write_mode | O_di_write | O_di_read_mode | O_di_read) !== '0) begin
            failures++; $display("FAIL rst_busy_async got wm=%b w=%b want 00", O_di_write_mode, O_di_write);
        end
        @(posedge ifclk);
        @(negedge ifclk);
        di_write_mode = 1'b0; di_write = 1'b0;
        stall_inf[1] = 1'b0; stall[1] = 0; dev_status[1] = 16'h2C2C;
        resetb = 1'b1;
        run_txn(1'b0, 16'h0011, 32'h0000_1111, 1'b0);
        checks++;
        if (r_viol !== 0 || r_lat !== 1 || r_status !== 16'h2C2C) begin
            failures++; $display("FAIL rst_busy_after got viol %0d lat %0d st %h want 0/1/2c2c", r_viol, r_lat, r_status);
        end
    endtask

    task automatic test_random();
        bit          rd, req;
        logic [15:0] term;
        int          d, e_lat, e_unm, e_to, e_req;
        logic [31:0] e_data;
        logic [15:0] e_status;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 3))
                0:       term = {12'h000, 4'($urandom_range(0, 15))};
                1:       term = {12'h001, 4'($urandom_range(0, 15))};
                2:       term = 16'($urandom_range(32'h20, 32'hFFFF));
                default: term = 16'($urandom);
            endcase
            rd  = 1'($urandom_range(0, 1));
            req = rd & 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) begin
                stall[k] = $urandom_range(0, 9);
                dev_rdata[k] = $urandom;
                dev_status[k] = 16'($urandom);
            end
            d = ref_decode(term);
            e_unm = 0; e_to = 0; e_req = 0;
            if (d < 0) begin
                e_lat = 1; e_data = 32'hDEAD_BEEF; e_status = 16'hE001; e_unm = 1;
            end else if (stall[d] >= TO) begin
                e_lat = TO + 1; e_data = 32'hDEAD_BEEF; e_status = 16'hE002; e_to = 1; e_req = req;
            end else begin
                e_lat = stall[d] + 1; e_data = dev_rdata[d]; e_status = dev_status[d]; e_req = req;
            end
            run_txn(rd, term, 32'($urandom), req);
            checks++;
            if (r_lat !== e_lat || r_status !== e_status) begin
                failures++; $display("FAIL rand_resp[%0d] term %h got lat %0d st %h want %0d %h", n, term, r_lat, r_status, e_lat, e_status);
            end
            if (rd) begin
                checks++;
                if (r_data !== e_data) begin
                    failures++; $display("FAIL rand_data[%0d] term %h got %h want %h", n, term, r_data, e_data);
                end
            end
            checks++;
            if (r_viol !== 0 || r_unm !== e_unm || r_to !== e_to || r_req !== e_req) begin
                failures++;
                $display("FAIL rand_side[%0d] term %h got viol %0d unm %0d to %0d req %0d want 0 %0d %0d %0d",
                         n, term, r_viol, r_unm, r_to, r_req, e_unm, e_to, e_req);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int k = 0; k < N; k++) begin
            stall[k] = 0; stall_inf[k] = 1'b0; dev_rdata[k] = '0; dev_status[k] = '0;
        end
        test_reset();
        test_map_decode();
        test_replay_req();
        test_unmapped();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit got no finish want finish before 400000");
        $fatal(1);
    end

endmodule

// File: doc/hi_term_decoder.md
# hi_term_decoder

Splits one Host Interface device bus into NUM_DEVS device buses by terminal address. It sits between a host (or the output of the host arbiter) and the terminal devices. The target device is selected once per transaction and latched. The block answers on its own for unmapped terminals and for devices that stall past a watchdog limit, so the host never hangs.

## Interface
- NUM_DEVS, 2: number of device ports.
- TERM_BASE, {NUM_DEVS{16'h0}}: packed 16·NUM_DEVS; slice k is the base address of device k.
- TERM_MASK, {NUM_DEVS{16'hFFFF}}: packed 16·NUM_DEVS. Device k matches when (di_term_addr & mask_k) == base_k. Lowest matching k wins.
- TIMEOUT_CYCLES, 1024: stall limit in cycles. 0 disables the watchdog.

Ports:
- ifclk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- di_term_addr / di_reg_addr / di_len  in  16/32/32  host transaction address and length
- di_read_mode, di_read_req, di_read  in  1 each  host read controls
- di_read_rdy  out  1;  di_reg_datao  out  32  read handshake and read data to host
- di_write_mode, di_write  in  1 each;  di_reg_datai  in  32  host write controls and write data
- di_write_rdy  out  1;  di_transfer_status  out  16  write handshake and status to host
- O_di_term_addr[k], O_di_reg_addr[k], O_di_len[k], O_di_reg_datai[k]  out  16/32/32/32 per device  broadcast copies of the host inputs
- O_di_read_mode[k], O_di_read_req[k], O_di_read[k], O_di_write_mode[k], O_di_write[k]  out  1 per device  gated controls
- I_di_read_rdy[k], I_di_write_rdy[k]  in  1 per device  device handshakes
- I_di_reg_datao[k]  in  32 per device  device read data
- I_di_transfer_status[k]  in  16 per device  device status
- unmapped_evt, timeout_evt  out  1 each  one-cycle registered error pulses

## Operation
- Address, length and write-data outputs are combinational copies of the host inputs to every device, in every state.
- The FSM has four states: IDLE, BUSY, UNMAPPED, TIMEOUT. Registers are state, sel (the latched device index), pend_req and the watchdog counter.
- **IDLE**
  - The cycle in which mode = di_read_mode|di_write_mode is high is the decode cycle.
  - On the decode cycle, sel latches the first matching device and the next state is BUSY. If no device matches, the next state is UNMAPPED and unmapped_evt pulses next cycle.
  - During IDLE, all device controls are 0. di_read_rdy, di_write_rdy, di_reg_datao and di_transfer_status are 0.
  - A di_read_req seen on the decode cycle sets pend_req.
- **BUSY**
  - O_*_mode, O_di_read, O_di_write and O_di_read_req go to device sel only; all other devices see 0.
  - O_di_read_req[sel] = di_read_req | pend_req. pend_req clears after its first BUSY cycle, so the replayed request is exactly one cycle.
  - Host rdy, data and status are muxed from device sel.
  - The term address is not re-decoded during BUSY; changes to di_term_addr are ignored until IDLE.
- **UNMAPPED / TIMEOUT**
  - All device controls are 0.
  - di_read_rdy = di_write_rdy = 1. di_reg_datao = 32'hDEAD_BEEF.
  - di_transfer_status = 16'hE001 in UNMAPPED, 16'hE002 in TIMEOUT.
  - Host reads and writes are accepted and discarded.
- **Watchdog (BUSY only)**
  - The counter increments on each cycle where the relevant rdy is low: read rdy if di_read_mode, else write rdy. It clears when that rdy is high, and on entry to BUSY.
  - When the count reaches TIMEOUT_CYCLES, the next state is TIMEOUT and timeout_evt pulses.
- Any state returns to IDLE on the cycle after mode is low.
- If mode is low for one cycle, the following cycle can be a new decode cycle.

## Timing
- Reset state: IDLE, sel=0, pend_req=0, counter=0.
  - All device controls, host rdy/data/status and the evt outputs are 0.
  - Broadcast outputs follow their inputs.
- Asserting resetb low mid-transaction drops device modes immediately, asynchronously.
- Added latency: one decode cycle from host mode rising to O_*_mode rising. After that, the handshake path is combinational with zero added cycles.
- Mode fall: device mode falls in the same cycle as host mode; the state is IDLE on the next cycle.
- TIMEOUT_CYCLES=N: TIMEOUT is entered on the cycle after the N-th consecutive not-ready BUSY cycle.
- A read_req arriving in the same cycle as the BUSY entry is OR'ed with pend_req. The device sees a single one-cycle pulse.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it does not wrap.

## Test plan
- **Map decode:** TERM_BASE={16'h0010,16'h0000}, TERM_MASK={16'hFFF0,16'hFFF0}. Write term 16'h0013 with data 32'h1234_5678 → only device 1 sees write_mode, starting one cycle after the host; device 0 controls stay 0; the write completes with device 1's status.
- **Replayed read_req:** read_req pulses on the decode cycle for term 16'h0002 → O_di_read_req[0] pulses exactly one cycle, on the first BUSY cycle; data from device 0 returns unchanged.
- **Unmapped terminal:** read of term 16'h0100 → unmapped_evt for one cycle; read_rdy=1; data 32'hDEAD_BEEF; status 16'hE001; no device mode asserts.
- **Watchdog:** TIMEOUT_CYCLES=8 and device 0 holds read_rdy low → after 8 stalled cycles, device 0 mode drops, timeout_evt pulses, and the host gets rdy with status 16'hE002. With TIMEOUT_CYCLES=0, the host stalls indefinitely.
- **Back-to-back:** a transaction to device 0, one idle cycle, then a transaction to device 1 → sel switches, with no overlap of device modes.
- **Reset mid-BUSY:** resetb asserted with write_mode active → all device controls go to 0 immediately. After release the state is IDLE, and a new transaction decodes normally.
